ring_mem_stop: RTL and testbench

- Memory-side ring stop. It sits directly downstream of the data/instruction cache ring ports and consumes the Address and WriteData slots those caches emit.
- Converts consumed slots into memory commands on a simple line-burst memory port (8 words per line).
- Returns read lines on the separate read-data return ring as RDreturn/RDdest, which the caches compare against their whichCore.
- All other slots are forwarded unchanged through a one-cycle ring pipeline stage.

---
 rtl/ring_mem_stop.sv | 198 +++++++++++++++++++
 tb/tb_ring_mem_stop.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_mem_stop.sv
// Memory-side ring stop: consumes cache Address/WriteData slots, issues 8-word line bursts,
// and returns read lines on RDreturn/RDdest. Define MEMSTOP_STATS_EN to add line counters.
module ring_mem_stop #(
   parameter int unsigned CMDQ_DEPTH = 4,
   parameter int unsigned WBUF_WORDS = 32,
   parameter logic [3:0]  NODEST     = 4'd0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] RingIn,
   input  logic [3:0]  SlotTypeIn,
   input  logic [3:0]  SrcDestIn,
   output logic [31:0] RingOut,
   output logic [3:0]  SlotTypeOut,
   output logic [3:0]  SrcDestOut,
   output logic [31:0] RDreturn,
   output logic [3:0]  RDdest,
   output logic        memCmdValid,
   input  logic        memCmdReady,
   output logic        memCmdRead,
   output logic [27:0] memCmdAddr,
   output logic [31:0] memWdata,
   output logic        memWvalid,
   input  logic        memWready,
   input  logic [31:0] memRdata,
   input  logic        memRvalid,
   output logic        errFlag
`ifdef MEMSTOP_STATS_EN
   ,
   output logic [15:0] rdLines,
   output logic [15:0] wrLines
`endif
);

   localparam int unsigned CQ_AW = $clog2(CMDQ_DEPTH);
   localparam int unsigned WB_AW = $clog2(WBUF_WORDS);
   localparam logic [3:0]  ST_ADDR  = 4'd2;
   localparam logic [3:0]  ST_WDATA = 4'd3;
   localparam logic [3:0]  ST_NULL  = 4'd7;

   typedef enum logic [1:0] {IDLE, ISSUE, WDATA, RWAIT} state_t;

   state_t            state_q, state_d;
   logic [2:0]        beat_q, beat_d;
   logic [31:0]       ring_q;
   logic [3:0]        type_q, srcd_q;
   logic [31:0]       rdret_q;
   logic [3:0]        rddest_q, src_q;
   logic              err_q;

   logic [32:0]       cq_mem [CMDQ_DEPTH];
   logic [CQ_AW-1:0]  cq_wp_q, cq_rp_q;
   logic [CQ_AW:0]    cq_cnt_q;
   logic [31:0]       wb_mem [WBUF_WORDS];
   logic [WB_AW-1:0]  wb_wp_q, wb_rp_q;
   logic [WB_AW:0]    wb_cnt_q, wb_rsv_q, wb_unrsv;

   logic        is_wd, is_addr, addr_read, words_short;
   logic        cq_full, cq_push, cq_pop, cq_drop;
   logic        wb_full, wb_push, wb_pop, wb_drop;
   logic [32:0] cq_head;
   logic        unused_ifetch;

   assign unused_ifetch = RingIn[29];

   assign is_wd     = (SlotTypeIn == ST_WDATA);
   assign is_addr   = (SlotTypeIn == ST_ADDR) && (RingIn[31:30] == 2'b00);
   assign addr_read = RingIn[28];

   assign cq_head = cq_mem[cq_rp_q];
   assign cq_full = (cq_cnt_q == (CQ_AW+1)'(CMDQ_DEPTH));
   assign wb_full = (wb_cnt_q == (WB_AW+1)'(WBUF_WORDS));
   assign cq_pop  = (state_q == ISSUE) && memCmdReady;
   assign wb_pop  = (state_q == WDATA) && memWready;

   // A pop in the same cycle frees the slot a push to a full FIFO needs.
   assign wb_push  = is_wd && (!wb_full || wb_pop);
   assign wb_drop  = is_wd && !wb_push;
   assign wb_unrsv = wb_cnt_q - wb_rsv_q;
   assign words_short = !addr_read && (wb_unrsv < (WB_AW+1)'(8));
   assign cq_push  = is_addr && !words_short && (!cq_full || cq_pop);
   assign cq_drop  = is_addr && !cq_push;

   assign memCmdRead = cq_head[32];
   assign memCmdAddr = cq_head[31:4];
   assign memWdata   = wb_mem[wb_rp_q];

   assign RingOut     = ring_q;
   assign SlotTypeOut = type_q;
   assign SrcDestOut  = srcd_q;
   assign RDreturn    = rdret_q;
   assign RDdest      = rddest_q;
   assign errFlag     = err_q;

   // NOTE: storage arrays carry no reset; the pointers and counts define what is valid.
   always_ff @(posedge clock) begin
      if (cq_push) cq_mem[cq_wp_q] <= {addr_read, RingIn[27:0], SrcDestIn};
      if (wb_push) wb_mem[wb_wp_q] <= RingIn;
   end

   // NOTE: all sequential state is updated with non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         beat_q   <= 3'd0;
         ring_q   <= 32'd0;
         type_q   <= ST_NULL;
         srcd_q   <= 4'd0;
         rdret_q  <= 32'd0;
         rddest_q <= NODEST;
         src_q    <= 4'd0;
         err_q    <= 1'b0;
         cq_wp_q  <= '0;
         cq_rp_q  <= '0;
         cq_cnt_q <= '0;
         wb_wp_q  <= '0;
         wb_rp_q  <= '0;
         wb_cnt_q <= '0;
         wb_rsv_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         if (is_wd || is_addr) begin
            ring_q <= 32'd0;
            type_q <= ST_NULL;
            srcd_q <= 4'd0;
         end else begin
            ring_q <= RingIn;
            type_q <= SlotTypeIn;
            srcd_q <= SrcDestIn;
         end
         if (state_q == RWAIT && memRvalid) begin
            rdret_q  <= memRdata;
            rddest_q <= src_q;
         end else begin
            rddest_q <= NODEST;
         end
         if (cq_pop) src_q <= cq_head[3:0];
         err_q <= err_q | wb_drop | cq_drop;

         if (cq_push) cq_wp_q <= cq_wp_q + 1'b1;
         if (cq_pop)  cq_rp_q <= cq_rp_q + 1'b1;
         if (cq_push && !cq_pop)      cq_cnt_q <= cq_cnt_q + 1'b1;
         else if (!cq_push && cq_pop) cq_cnt_q <= cq_cnt_q - 1'b1;

         if (wb_push) wb_wp_q <= wb_wp_q + 1'b1;
         if (wb_pop)  wb_rp_q <= wb_rp_q + 1'b1;
         if (wb_push && !wb_pop)      wb_cnt_q <= wb_cnt_q + 1'b1;
         else if (!wb_push && wb_pop) wb_cnt_q <= wb_cnt_q - 1'b1;

         // Reserved words drain one per write beat and grow by a line per accepted write.
         wb_rsv_q <= wb_rsv_q + ((cq_push && !addr_read) ? (WB_AW+1)'(8) : '0)
                              - (wb_pop ? (WB_AW+1)'(1) : '0);
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      memCmdValid = 1'b0;
      memWvalid   = 1'b0;
      case (state_q)
         IDLE:  if (cq_cnt_q != '0) state_d = ISSUE;
         ISSUE: begin
            memCmdValid = 1'b1;
            if (memCmdReady) state_d = cq_head[32] ? RWAIT : WDATA;
         end
         WDATA: begin
            memWvalid = 1'b1;
            if (memWready) begin
               beat_d = beat_q + 3'd1;
               if (beat_q == 3'd7) state_d = IDLE;
            end
         end
         RWAIT: begin
            if (memRvalid) begin
               beat_d = beat_q + 3'd1;
               if (beat_q == 3'd7) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef MEMSTOP_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdLines <= 16'd0;
         wrLines <= 16'd0;
      end else if (cq_pop) begin
         if (cq_head[32] && rdLines != 16'hFFFF)  rdLines <= rdLines + 16'd1;
         if (!cq_head[32] && wrLines != 16'hFFFF) wrLines <= wrLines + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ring_mem_stop.sv
// Directed bench for ring_mem_stop: table-driven ring-stage vectors plus hand-written
// read, write, dirty-miss, error and mid-burst reset sequences.
module tb_ring_mem_stop;

   localparam logic [3:0] NODEST = 4'd0;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] RingIn;
   logic [3:0]  SlotTypeIn, SrcDestIn;
   logic [31:0] RingOut;
   logic [3:0]  SlotTypeOut, SrcDestOut;
   logic [31:0] RDreturn;
   logic [3:0]  RDdest;
   logic        memCmdValid, memCmdReady, memCmdRead;
   logic [27:0] memCmdAddr;
   logic [31:0] memWdata;
   logic        memWvalid, memWready;
   logic [31:0] memRdata;
   logic        memRvalid;
   logic        errFlag;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       name;
      logic [3:0]  st;
      logic [31:0] ring;
      logic [3:0]  src;
      logic [31:0] exp_ring;
      logic [3:0]  exp_st;
      logic [3:0]  exp_src;
   } vec_t;

   vec_t vecs[7];

   ring_mem_stop dut (
      .clock(clock), .reset(reset),
      .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SrcDestIn(SrcDestIn),
      .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SrcDestOut(SrcDestOut),
      .RDreturn(RDreturn), .RDdest(RDdest),
      .memCmdValid(memCmdValid), .memCmdReady(memCmdReady),
      .memCmdRead(memCmdRead), .memCmdAddr(memCmdAddr),
      .memWdata(memWdata), .memWvalid(memWvalid), .memWready(memWready),
      .memRdata(memRdata), .memRvalid(memRvalid),
      .errFlag(errFlag)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_ring();
      RingIn     = 32'd0;
      SlotTypeIn = 4'd7;
      SrcDestIn  = 4'd0;
   endtask

   task automatic send_slot(input logic [3:0] st, input logic [31:0] ring, input logic [3:0] src);
      SlotTypeIn = st;
      RingIn     = ring;
      SrcDestIn  = src;
      step();
      idle_ring();
   endtask

   task automatic do_reset();
      memCmdReady = 1'b0;
      memWready   = 1'b0;
      memRvalid   = 1'b0;
      memRdata    = 32'd0;
      idle_ring();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic wait_cmd(input int max_cycles, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (memCmdValid) begin
            seen = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic accept_cmd(input string tag, input logic rd, input logic [27:0] addr);
      bit seen;
      wait_cmd(20, seen);
      check({tag, " cmd seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, " cmd read"}, 32'(memCmdRead), 32'(rd));
         check({tag, " cmd addr"}, 32'(memCmdAddr), 32'(addr));
         memCmdReady = 1'b1;
         step();
         memCmdReady = 1'b0;
      end
   endtask

   task automatic read_burst(input string tag, input logic [3:0] src, input logic [31:0] base);
      for (int i = 0; i < 8; i++) begin
         memRvalid = 1'b1;
         memRdata  = base + 32'(i);
         step();
         memRvalid = 1'b0;
         check({tag, " rd dest"}, 32'(RDdest), 32'(src));
         check({tag, " rd data"}, RDreturn, base + 32'(i));
         if (i == 3) begin
            step();
            check({tag, " rd gap dest"}, 32'(RDdest), 32'(NODEST));
         end
      end
      step();
      check({tag, " rd end dest"}, 32'(RDdest), 32'(NODEST));
   endtask

   task automatic write_burst(input string tag, input logic [31:0] base);
      int beat = 0;
      for (int k = 0; k < 40 && beat < 8; k++) begin
         memWready = k[0];
         if (memWvalid && memWready) begin
            check({tag, " wdata"}, memWdata, base + 32'(beat));
            beat++;
         end
         step();
      end
      memWready = 1'b0;
      check({tag, " beats"}, 32'(beat), 32'd8);
      check({tag, " wvalid end"}, 32'(memWvalid), 32'd0);
   endtask

   initial begin
      bit seen;
      int cmds;

      vecs[0] = '{"token",      4'd1, 32'h0000_0009, 4'd0, 32'h0000_0009, 4'd1, 4'd0};
      vecs[1] = '{"addr hi10",  4'd2, 32'h8000_0055, 4'd6, 32'h8000_0055, 4'd2, 4'd6};
      vecs[2] = '{"readdata",   4'd4, 32'hDEAD_BEEF, 4'd2, 32'hDEAD_BEEF, 4'd4, 4'd2};
      vecs[3] = '{"wdata eat",  4'd3, 32'h0000_CAFE, 4'd4, 32'h0000_0000, 4'd7, 4'd0};
      vecs[4] = '{"null",       4'd7, 32'h0000_1234, 4'd1, 32'h0000_1234, 4'd7, 4'd1};
      vecs[5] = '{"addr hi01",  4'd2, 32'h4000_0001, 4'd3, 32'h4000_0001, 4'd2, 4'd3};
      vecs[6] = '{"type5",      4'd5, 32'h0000_0077, 4'd4, 32'h0000_0077, 4'd5, 4'd4};

      reset = 1'b1;
      memCmdReady = 1'b0;
      memWready   = 1'b0;
      memRvalid   = 1'b0;
      memRdata    = 32'd0;
      idle_ring();
      #12;
      check("rst RingOut",     RingOut, 32'd0);
      check("rst SlotTypeOut", 32'(SlotTypeOut), 32'd7);
      check("rst SrcDestOut",  32'(SrcDestOut), 32'd0);
      check("rst RDreturn",    RDreturn, 32'd0);
      check("rst RDdest",      32'(RDdest), 32'(NODEST));
      check("rst errFlag",     32'(errFlag), 32'd0);
      check("rst cmdValid",    32'(memCmdValid), 32'd0);
      check("rst wvalid",      32'(memWvalid), 32'd0);
      reset = 1'b0;
      step();

      // Ring stage, back-to-back slots with one-cycle latency.
      for (int i = 0; i < 7; i++) begin
         SlotTypeIn = vecs[i].st;
         RingIn     = vecs[i].ring;
         SrcDestIn  = vecs[i].src;
         step();
         check({vecs[i].name, " ring"}, RingOut, vecs[i].exp_ring);
         check({vecs[i].name, " type"}, 32'(SlotTypeOut), 32'(vecs[i].exp_st));
         check({vecs[i].name, " src"},  32'(SrcDestOut), 32'(vecs[i].exp_src));
      end
      idle_ring();
      step();
      check("pass errFlag", 32'(errFlag), 32'd0);
      check("pass no cmd",  32'(memCmdValid), 32'd0);

      // Single read from core 3.
      do_reset();
      send_slot(4'd1, 32'd9, 4'd0);
      send_slot(4'd2, 32'h1000_0040, 4'd3);
      check("rd consumed ring", RingOut, 32'd0);
      check("rd consumed type", 32'(SlotTypeOut), 32'd7);
      accept_cmd("single", 1'b1, 28'h000_0040);
      read_burst("single", 4'd3, 32'd0);

      // Write line from core 2 with stalling memWready.
      do_reset();
      for (int i = 0; i < 8; i++) send_slot(4'd3, 32'hA0 + 32'(i), 4'd2);
      check("wr no early cmd", 32'(memCmdValid), 32'd0);
      send_slot(4'd2, 32'h0000_1234, 4'd2);
      accept_cmd("write", 1'b0, 28'h000_1234);
      write_burst("write", 32'hA0);
      check("write errFlag", 32'(errFlag), 32'd0);

      // Dirty miss: read must precede write.
      do_reset();
      send_slot(4'd2, 32'h1000_0010, 4'd5);
      for (int i = 0; i < 8; i++) send_slot(4'd3, 32'hB0 + 32'(i), 4'd5);
      send_slot(4'd2, 32'h0000_0020, 4'd5);
      check("dirty pre dest", 32'(RDdest), 32'(NODEST));
      accept_cmd("dirty first", 1'b1, 28'h000_0010);
      read_burst("dirty", 4'd5, 32'h100);
      accept_cmd("dirty second", 1'b0, 28'h000_0020);
      write_burst("dirty", 32'hB0);
      check("dirty post dest", 32'(RDdest), 32'(NODEST));
      check("dirty errFlag", 32'(errFlag), 32'd0);

      // Write address with only 7 buffered words.
      do_reset();
      for (int i = 0; i < 7; i++) send_slot(4'd3, 32'hC0 + 32'(i), 4'd1);
      check("short err before", 32'(errFlag), 32'd0);
      send_slot(4'd2, 32'h0000_0100, 4'd1);
      check("short errFlag", 32'(errFlag), 32'd1);
      wait_cmd(20, seen);
      check("short no cmd", 32'(seen), 32'd0);

      // Command FIFO overflow with memory stalled.
      do_reset();
      for (int i = 0; i < 4; i++) send_slot(4'd2, 32'h1000_0001 + 32'(i), 4'd1);
      check("cq err before", 32'(errFlag), 32'd0);
      send_slot(4'd2, 32'h1000_0005, 4'd1);
      check("cq overflow err", 32'(errFlag), 32'd1);
      cmds = 0;
      for (int n = 0; n < 5; n++) begin
         wait_cmd(20, seen);
         if (!seen) break;
         check("cq order addr", 32'(memCmdAddr), 32'(n + 1));
         memCmdReady = 1'b1;
         step();
         memCmdReady = 1'b0;
         read_burst("cq", 4'd1, 32'h200 + 32'(n * 8));
         cmds++;
      end
      check("cq issued count", 32'(cmds), 32'd4);

      // Reset in the middle of a read burst.
      do_reset();
      send_slot(4'd2, 32'h1000_0080, 4'd6);
      accept_cmd("mid", 1'b1, 28'h000_0080);
      for (int i = 0; i < 3; i++) begin
         memRvalid = 1'b1;
         memRdata  = 32'h300 + 32'(i);
         step();
      end
      memRvalid = 1'b0;
      check("mid pre dest", 32'(RDdest), 32'd6);
      #2;
      reset = 1'b1;
      #1;
      check("mid rst dest",     32'(RDdest), 32'(NODEST));
      check("mid rst cmdValid", 32'(memCmdValid), 32'd0);
      step();
      reset = 1'b0;
      step();
      wait_cmd(10, seen);
      check("mid no leftover cmd", 32'(seen), 32'd0);
      send_slot(4'd2, 32'h1000_0090, 4'd7);
      accept_cmd("post", 1'b1, 28'h000_0090);
      read_burst("post", 4'd7, 32'h400);

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no end, expected summary");
      $fatal(1);
   end

endmodule
